// File: rtl/cpu_pkg.sv
// Shared definitions for the cpu control path: opcodes, ALU op codes,
// write-back select codes, sequencer states and the decoded-control bundle.
package cpu_pkg;

    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0100;
    localparam logic [3:0] OP_SUB  = 4'b0101;
    localparam logic [3:0] OP_BEQ  = 4'b1000;
    localparam logic [3:0] OP_ADDI = 4'b1100;
    localparam logic [3:0] OP_LUI  = 4'b1101;
    localparam logic [3:0] OP_LW   = 4'b1110;
    localparam logic [3:0] OP_SW   = 4'b1111;

    typedef enum logic [3:0] {
        ALU_ADD = 4'h0,
        ALU_SUB = 4'h1
    } alu_op_t;

    typedef enum logic [1:0] {
        WB_ALU = 2'b00,
        WB_MEM = 2'b01,
        WB_LUI = 2'b10
    } wb_sel_t;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB
    } state_t;

    typedef struct packed {
        alu_op_t alu;
        logic    alu_src_imm;
        wb_sel_t wb_sel;
        logic    is_mem;
        logic    is_st;
        logic    is_br;
        logic    writes_rd;
        logic    illegal;
    } dec_t;

endpackage

// File: rtl/cpu_decode.sv
// Combinational opcode decoder: maps the latched opcode to the static
// control bundle the sequencer uses to steer EXEC/MEM/WB.
module cpu_decode
    import cpu_pkg::*;
(
    input  logic [3:0] i_opcode,
    output dec_t       o_dec
);

    // Opcode to control-bundle lookup; undefined opcodes flag illegal.
    always_comb begin
        // NOTE: every field gets a default before the case so no latch is inferred.
        o_dec = '0;
        case (i_opcode)
            OP_NOP:  ;
            OP_ADD:  o_dec.writes_rd = 1'b1;
            OP_SUB:  begin o_dec.alu = ALU_SUB; o_dec.writes_rd = 1'b1; end
            OP_BEQ:  begin o_dec.alu = ALU_SUB; o_dec.is_br = 1'b1; end
            OP_ADDI: begin o_dec.alu_src_imm = 1'b1; o_dec.writes_rd = 1'b1; end
            OP_LUI:  begin o_dec.wb_sel = WB_LUI; o_dec.writes_rd = 1'b1; end
            OP_LW:   begin
                o_dec.alu_src_imm = 1'b1;
                o_dec.wb_sel      = WB_MEM;
                o_dec.is_mem      = 1'b1;
                o_dec.writes_rd   = 1'b1;
            end
            OP_SW:   begin
                o_dec.alu_src_imm = 1'b1;
                o_dec.is_mem      = 1'b1;
                o_dec.is_st       = 1'b1;
            end
            default: o_dec.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle control FSM for the cpu datapath (FETCH/DECODE/EXEC/MEM/WB),
// one instruction in flight, req/ready memory port with optional wait limit.
// Optional feature: define CPU_SEQ_RETIRE_CNT_EN to enable retire_count;
// otherwise retire_count is tied to zero.
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 0,
    parameter int RETIRE_W     = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         instruction,
    input  logic                mem_ready,
    input  logic                Eq,
    output logic                mem_req,
    output logic                mem_we,
    output logic                addr_sel,
    output logic                ir_we,
    output logic                pc_inc,
    output logic                pc_branch,
    output logic                alu_src_imm,
    output logic [3:0]          ALU,
    output logic [1:0]          wb_sel,
    output logic                Wr_en,
    output logic                retired,
    output logic                illegal,
    output logic                mem_err,
    output logic [RETIRE_W-1:0] retire_count
);

    localparam int WAIT_W = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((MEM_WAIT_MAX > 0) ? MEM_WAIT_MAX - 1 : 0);

    state_t              r_state;
    logic [3:0]          r_opcode;
    logic                r_mem_req;
    logic                r_mem_we;
    logic                r_addr_sel;
    alu_op_t             r_alu;
    logic                r_alu_src_imm;
    wb_sel_t             r_wb_sel;
    logic                r_wr_en;
    logic                r_illegal;
    logic                r_mem_err;
    logic [WAIT_W-1:0]   r_wait_cnt;

    dec_t                w_dec;
    logic                w_hs;
    logic                w_timeout;
    logic                w_exec_retire;
    logic                w_retired;
    logic                w_unused;

    // Only the opcode field of the fetched word matters to the sequencer.
    assign w_unused = ^instruction[27:0];

    cpu_decode u_decode (
        .i_opcode (r_opcode),
        .o_dec    (w_dec)
    );

    assign w_hs          = r_mem_req && mem_ready;
    assign w_timeout     = (MEM_WAIT_MAX > 0) && r_mem_req && !mem_ready && (r_wait_cnt == WAIT_LAST);
    assign w_exec_retire = !w_dec.illegal && !w_dec.is_mem && !w_dec.writes_rd;
    assign w_retired     = !rst && (((r_state == S_EXEC) && w_exec_retire) ||
                                    ((r_state == S_MEM) && w_hs && w_dec.is_st) ||
                                    (r_state == S_WB));

    // Sequencer state, registered Moore controls and memory wait counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_FETCH;
            r_opcode      <= '0;
            r_mem_req     <= 1'b0;
            r_mem_we      <= 1'b0;
            r_addr_sel    <= 1'b0;
            r_alu         <= ALU_ADD;
            r_alu_src_imm <= 1'b0;
            r_wb_sel      <= WB_ALU;
            r_wr_en       <= 1'b0;
            r_illegal     <= 1'b0;
            r_mem_err     <= 1'b0;
            r_wait_cnt    <= '0;
        end else begin
            // NOTE: non-blocking only, so every branch sees the pre-edge state.
            r_illegal <= 1'b0;
            r_mem_err <= 1'b0;
            if (r_mem_req && !mem_ready && !w_timeout)
                r_wait_cnt <= r_wait_cnt + 1'b1;
            else
                r_wait_cnt <= '0;

            case (r_state)
                S_FETCH: begin
                    // A fresh request is raised one cycle after reset or a timeout.
                    if (!r_mem_req) begin
                        r_mem_req <= 1'b1;
                    end else if (mem_ready) begin
                        r_mem_req <= 1'b0;
                        r_opcode  <= instruction[31:28];
                        r_state   <= S_DECODE;
                    end else if (w_timeout) begin
                        r_mem_req <= 1'b0;
                        r_mem_err <= 1'b1;
                    end
                end
                S_DECODE: begin
                    r_state       <= S_EXEC;
                    r_alu         <= w_dec.alu;
                    r_alu_src_imm <= w_dec.alu_src_imm;
                    r_illegal     <= w_dec.illegal;
                end
                S_EXEC: begin
                    if (w_dec.is_mem) begin
                        r_state    <= S_MEM;
                        r_mem_req  <= 1'b1;
                        r_mem_we   <= w_dec.is_st;
                        r_addr_sel <= 1'b1;
                    end else if (w_dec.writes_rd) begin
                        r_state  <= S_WB;
                        r_wr_en  <= 1'b1;
                        r_wb_sel <= w_dec.wb_sel;
                    end else begin
                        r_state       <= S_FETCH;
                        r_mem_req     <= 1'b1;
                        r_alu         <= ALU_ADD;
                        r_alu_src_imm <= 1'b0;
                    end
                end
                S_MEM: begin
                    if (w_hs) begin
                        r_mem_we   <= 1'b0;
                        r_addr_sel <= 1'b0;
                        if (w_dec.is_st) begin
                            r_state       <= S_FETCH;
                            r_mem_req     <= 1'b1;
                            r_alu         <= ALU_ADD;
                            r_alu_src_imm <= 1'b0;
                        end else begin
                            r_state   <= S_WB;
                            r_mem_req <= 1'b0;
                            r_wr_en   <= 1'b1;
                            r_wb_sel  <= w_dec.wb_sel;
                        end
                    end else if (w_timeout) begin
                        // Abandon the access; PC was already advanced at fetch.
                        r_state       <= S_FETCH;
                        r_mem_req     <= 1'b0;
                        r_mem_we      <= 1'b0;
                        r_addr_sel    <= 1'b0;
                        r_mem_err     <= 1'b1;
                        r_alu         <= ALU_ADD;
                        r_alu_src_imm <= 1'b0;
                    end
                end
                S_WB: begin
                    r_state       <= S_FETCH;
                    r_mem_req     <= 1'b1;
                    r_wr_en       <= 1'b0;
                    r_wb_sel      <= WB_ALU;
                    r_alu         <= ALU_ADD;
                    r_alu_src_imm <= 1'b0;
                end
                default: r_state <= S_FETCH;
            endcase
        end
    end

    assign mem_req     = r_mem_req;
    assign mem_we      = r_mem_we;
    assign addr_sel    = r_addr_sel;
    assign alu_src_imm = r_alu_src_imm;
    assign ALU         = r_alu;
    assign wb_sel      = r_wb_sel;
    assign Wr_en       = r_wr_en;
    assign illegal     = r_illegal;
    assign mem_err     = r_mem_err;

    // Same-cycle strobes qualified by the handshake or the compare result.
    assign ir_we     = !rst && (r_state == S_FETCH) && w_hs;
    assign pc_inc    = !rst && (r_state == S_FETCH) && w_hs;
    assign pc_branch = !rst && (r_state == S_EXEC) && w_dec.is_br && Eq;
    assign retired   = w_retired;

`ifdef CPU_SEQ_RETIRE_CNT_EN
    logic [RETIRE_W-1:0] r_retire_count;

    // Count retired instructions, wrapping at the counter width.
    always_ff @(posedge clk) begin
        if (rst)
            r_retire_count <= '0;
        else if (w_retired)
            r_retire_count <= r_retire_count + 1'b1;
    end

    assign retire_count = r_retire_count;
`else
    assign retire_count = '0;
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: every cycle's expected control
// vector is queued as stimulus is driven and compared on the falling edge.
module tb_cpu_sequencer;

    localparam int WAIT_MAX = 4;
    localparam int RW       = 32;

    typedef struct packed {
        logic       req;
        logic       we;
        logic       asel;
        logic       ir_we;
        logic       pc_inc;
        logic       pc_br;
        logic       imm;
        logic [3:0] alu;
        logic [1:0] wb;
        logic       wr;
        logic       ret;
        logic       ill;
        logic       err;
    } ovec_t;

    typedef struct {
        string tag;
        ovec_t v;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   instruction;
    logic          mem_ready;
    logic          Eq;
    logic          mem_req, mem_we, addr_sel, ir_we, pc_inc, pc_branch;
    logic          alu_src_imm, Wr_en, retired, illegal, mem_err;
    logic [3:0]    ALU;
    logic [1:0]    wb_sel;
    logic [RW-1:0] retire_count;

    exp_t          sb[$];
    int            n_checks = 0;
    int            n_errors = 0;
    int            exp_retired = 0;
    ovec_t         obs;

    cpu_sequencer #(.MEM_WAIT_MAX(WAIT_MAX), .RETIRE_W(RW)) dut (
        .clk          (clk),
        .rst          (rst),
        .instruction  (instruction),
        .mem_ready    (mem_ready),
        .Eq           (Eq),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .addr_sel     (addr_sel),
        .ir_we        (ir_we),
        .pc_inc       (pc_inc),
        .pc_branch    (pc_branch),
        .alu_src_imm  (alu_src_imm),
        .ALU          (ALU),
        .wb_sel       (wb_sel),
        .Wr_en        (Wr_en),
        .retired      (retired),
        .illegal      (illegal),
        .mem_err      (mem_err),
        .retire_count (retire_count)
    );

    always #5 clk = ~clk;

    assign obs = '{req: mem_req, we: mem_we, asel: addr_sel, ir_we: ir_we, pc_inc: pc_inc,
                   pc_br: pc_branch, imm: alu_src_imm, alu: ALU, wb: wb_sel, wr: Wr_en,
                   ret: retired, ill: illegal, err: mem_err};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push(input string tag, input ovec_t v);
        exp_t e;
        e.tag = tag;
        e.v   = v;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare whatever the stimulus side expects for this cycle.
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            check(e.tag, 32'(obs), 32'(e.v));
        end
    end

    task automatic do_fetch(input string nm, input logic [31:0] ins, input int fwait);
        ovec_t v;
        instruction = ins;
        for (int i = 0; i < fwait; i++) begin
            mem_ready = 1'b0;
            v = '0; v.req = 1'b1;
            push({nm, ":fetch_wait"}, v);
            tick();
        end
        mem_ready = 1'b1;
        v = '0; v.req = 1'b1; v.ir_we = 1'b1; v.pc_inc = 1'b1;
        push({nm, ":fetch"}, v);
        tick();
        // Scramble the bus: the opcode must have been latched already.
        instruction = $urandom;
        mem_ready = 1'b0;
    endtask

    task automatic run_instr(input string nm, input logic [31:0] ins, input int fwait,
                             input int mwait, input logic eq);
        ovec_t v, base;
        logic [3:0] op, alu;
        logic [1:0] wb;
        logic imm, is_mem, is_st, is_br, is_nop, writes, ill, timed_out;
        op = ins[31:28];
        alu = 4'h0; wb = 2'b00; imm = 1'b0;
        is_mem = 1'b0; is_st = 1'b0; is_br = 1'b0; is_nop = 1'b0; writes = 1'b0; ill = 1'b0;
        timed_out = 1'b0;
        case (op)
            4'h0: is_nop = 1'b1;
            4'h4: writes = 1'b1;
            4'h5: begin alu = 4'h1; writes = 1'b1; end
            4'h8: begin alu = 4'h1; is_br = 1'b1; end
            4'hC: begin imm = 1'b1; writes = 1'b1; end
            4'hD: begin wb = 2'b10; writes = 1'b1; end
            4'hE: begin imm = 1'b1; wb = 2'b01; is_mem = 1'b1; writes = 1'b1; end
            4'hF: begin imm = 1'b1; is_mem = 1'b1; is_st = 1'b1; end
            default: ill = 1'b1;
        endcase

        do_fetch(nm, ins, fwait);

        // DECODE: ready and Eq are don't-cares with no request pending.
        mem_ready = 1'b1; Eq = 1'b1;
        push({nm, ":decode"}, '0);
        tick();

        mem_ready = 1'b0; Eq = eq;
        base = '0; base.alu = alu; base.imm = imm;
        v = base;
        if (ill) v.ill = 1'b1;
        else if (is_br) begin v.pc_br = eq; v.ret = 1'b1; end
        else if (is_nop) v.ret = 1'b1;
        push({nm, ":exec"}, v);
        tick();
        Eq = 1'b0;

        if (is_mem) begin
            v = base; v.req = 1'b1; v.asel = 1'b1; v.we = is_st;
            if (mwait >= WAIT_MAX) begin
                for (int i = 0; i < WAIT_MAX; i++) begin
                    push({nm, ":mem_wait"}, v);
                    tick();
                end
                mem_ready = 1'b1;
                v = '0; v.err = 1'b1;
                push({nm, ":mem_err"}, v);
                tick();
                mem_ready = 1'b0;
                timed_out = 1'b1;
            end else begin
                for (int i = 0; i < mwait; i++) begin
                    push({nm, ":mem_wait"}, v);
                    tick();
                end
                mem_ready = 1'b1;
                v.ret = is_st;
                push({nm, ":mem_done"}, v);
                tick();
                mem_ready = 1'b0;
            end
        end

        if (writes && !timed_out) begin
            v = base; v.wr = 1'b1; v.wb = wb; v.ret = 1'b1;
            push({nm, ":wb"}, v);
            tick();
        end

        if (!ill && !timed_out) exp_retired++;
    endtask

    task automatic fetch_timeout(input string nm, input logic [31:0] ins);
        ovec_t v;
        instruction = ins;
        mem_ready = 1'b0;
        for (int i = 0; i < WAIT_MAX; i++) begin
            v = '0; v.req = 1'b1;
            push({nm, ":fetch_wait"}, v);
            tick();
        end
        // Ready arriving after the drop must be ignored.
        mem_ready = 1'b1;
        v = '0; v.err = 1'b1;
        push({nm, ":mem_err"}, v);
        tick();
        mem_ready = 1'b0;
    endtask

    function automatic logic [31:0] exp_count();
`ifdef CPU_SEQ_RETIRE_CNT_EN
        return 32'(exp_retired);
`else
        return 32'h0;
`endif
    endfunction

    initial begin
        ovec_t v;
        rst = 1'b1; mem_ready = 1'b0; Eq = 1'b0; instruction = 32'h0;
        tick();
        tick();
        push("reset", '0);
        tick();
        rst = 1'b0;
        mem_ready = 1'b1;
        push("idle_ready_ignored", '0);
        tick();
        mem_ready = 1'b0;
        check("retire_count_reset", 32'(retire_count), 32'h0);

        run_instr("addi",     32'hC123_0001, 0, 0, 1'b0);
        run_instr("beq_eq1",  32'h8120_0000, 0, 0, 1'b1);
        run_instr("beq_eq0",  32'h8120_0000, 0, 0, 1'b0);
        run_instr("lw_wait3", 32'hE123_0004, 0, 3, 1'b0);
        run_instr("illegal",  32'h2123_0000, 0, 0, 1'b0);
        run_instr("add",      32'h4123_0000, 0, 0, 1'b0);
        run_instr("sub",      32'h5123_0000, 1, 0, 1'b1);
        run_instr("nop",      32'h0000_0000, 0, 0, 1'b0);
        run_instr("lui",      32'hD100_ABCD, 0, 0, 1'b0);
        run_instr("sw",       32'hF123_0008, 0, 0, 1'b0);
        run_instr("sw_wait2", 32'hF123_000C, 2, 2, 1'b0);
        run_instr("lw",       32'hE123_0010, 0, 0, 1'b0);
        run_instr("ill_9",    32'h9000_0000, 0, 0, 1'b0);
        fetch_timeout("fetch_to", 32'h4123_0000);
        run_instr("add_after_to", 32'h4123_0000, 3, 0, 1'b0);
        run_instr("lw_mem_to",    32'hE123_0014, 0, WAIT_MAX, 1'b0);
        run_instr("sw_wait3",     32'hF123_0018, 0, WAIT_MAX - 1, 1'b0);
        check("retire_count_mid", 32'(retire_count), exp_count());

        // Reset while a MEM access is outstanding.
        do_fetch("lw_rst", 32'hE123_0020, 0);
        push("lw_rst:decode", '0);
        tick();
        v = '0; v.imm = 1'b1;
        push("lw_rst:exec", v);
        tick();
        v.req = 1'b1; v.asel = 1'b1;
        push("lw_rst:mem", v);
        tick();
        rst = 1'b1;
        tick();
        exp_retired = 0;
        push("lw_rst:rst_hold", '0);
        check("retire_count_after_rst", 32'(retire_count), 32'h0);
        tick();
        rst = 1'b0;
        push("lw_rst:idle", '0);
        tick();

        run_instr("addi_post_rst", 32'hC000_0002, 0, 0, 1'b0);
        run_instr("beq_post_rst",  32'h8000_0000, 0, 0, 1'b1);
        check("retire_count_end", 32'(retire_count), exp_count());
        check("scoreboard_drained", 32'(sb.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench did not complete");
    end

endmodule
